// File: rtl/temp_fifo.sv
// temp_fifo: circular-buffer FIFO for temperature samples with registered flags and read data.
// Optional TEMP_FIFO_DROP_CNT_EN adds a saturating drop_count of rejected writes.
module temp_fifo #(
  parameter int DEPTH = 8,
  parameter int AF_LEVEL = 6,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        din,
  output logic              fifo_full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [7:0]        dout,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
`ifdef TEMP_FIFO_DROP_CNT_EN
  output logic [15:0]       drop_count,
`endif
  output logic              overflow
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  logic [ADDR_W:0] count_next;
  assign wr_ok = wr_en && !fifo_full;
  assign rd_ok = rd_en && !empty;
  always_comb begin
    count_next = (wr_ok && !rd_ok) ? count + 1'b1 :
                 (rd_ok && !wr_ok) ? count - 1'b1 : count;
  end
  // Memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      fifo_full <= 1'b0;
      almost_full <= 1'b0;
      empty <= 1'b1;
      dout <= 8'h00;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (rd_ok) dout <= mem[rd_ptr];
      rd_valid <= rd_ok;
      count <= count_next;
      fifo_full <= count_next == FULL_CNT;
      empty <= count_next == '0;
      almost_full <= count_next >= AF_CNT;
      if (wr_en && fifo_full) overflow <= 1'b1;
    end
  end
`ifdef TEMP_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_count <= '0;
    else if (wr_en && fifo_full && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_temp_fifo.sv
// tb_temp_fifo: randomized scoreboard bench for temp_fifo against a queue-based reference model.
module tb_temp_fifo;
  localparam int DEPTH = 8;
  localparam int AF_LEVEL = 6;
  logic clk = 0, reset = 0, wr_en = 0, rd_en = 0;
  logic [7:0] din = 0;
  logic fifo_full, almost_full, rd_valid, empty, overflow;
  logic [7:0] dout;
  logic [3:0] count;
`ifdef TEMP_FIFO_DROP_CNT_EN
  logic [15:0] drop_count;
`endif
  int total = 0, bad = 0;
  byte unsigned q[$];
  byte unsigned sb[$];
  bit exp_rv = 0, exp_ovf = 0;
  int exp_drops = 0;
  logic [7:0] last_dout = 0;

  temp_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .fifo_full(fifo_full),
    .almost_full(almost_full), .rd_en(rd_en), .dout(dout), .rd_valid(rd_valid),
    .empty(empty), .count(count),
`ifdef TEMP_FIFO_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sb.delete();
    exp_rv = 0;
    exp_ovf = 0;
    exp_drops = 0;
    last_dout = 0;
  endtask

  // Drive one clock of stimulus and advance the model by the FIFO rules.
  task automatic cycle(input bit w, input bit r, input byte unsigned d);
    bit full, emp;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din = d;
    @(posedge clk);
    full = q.size() == DEPTH;
    emp = q.size() == 0;
    if (w && full) begin
      exp_ovf = 1;
      if (exp_drops < 16'hFFFF) exp_drops++;
    end
    exp_rv = r && !emp;
    if (exp_rv) sb.push_back(q.pop_front());
    if (w && !full) q.push_back(d);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("count", int'(count), q.size());
      chk("fifo_full", int'(fifo_full), int'(q.size() == DEPTH));
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("almost_full", int'(almost_full), int'(q.size() >= AF_LEVEL));
      chk("overflow", int'(overflow), int'(exp_ovf));
      chk("rd_valid", int'(rd_valid), int'(exp_rv));
`ifdef TEMP_FIFO_DROP_CNT_EN
      chk("drop_count", int'(drop_count), exp_drops);
`endif
      if (rd_valid) begin
        if (sb.size() == 0) chk("sb_underrun", 1, 0);
        else begin
          last_dout = sb.pop_front();
          chk("dout", int'(dout), int'(last_dout));
        end
      end else chk("dout_hold", int'(dout), int'(last_dout));
    end
  end

  initial begin
    reset = 1;
    #12;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_dout", int'(dout), 0);
    reset = 0;
    repeat (3) cycle(0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 8'(8'h11 + i));
    cycle(1, 0, 8'hAA);
    cycle(0, 0, 0);
    cycle(1, 1, 8'hBB);
    cycle(0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) cycle(0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    cycle(1, 1, 8'h5C);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < 400; i++) cycle(1'($urandom), 1'($urandom), 8'($urandom));
    while (q.size() != 0) cycle(0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h70 + i));
    cycle(0, 0, 0);
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(fifo_full), 0);
    chk("arst_af", int'(almost_full), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_dout", int'(dout), 0);
    chk("arst_rv", int'(rd_valid), 0);
    chk("arst_ovf", int'(overflow), 0);
    model_reset();
    @(negedge clk);
    #1 reset = 0;
    cycle(1, 0, 8'h3D);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
